// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer.
// The STEP state exists only when SINGLE_STEP_EN is defined.
package pc_seq_pkg;

    localparam int PC_W       = 32;
    localparam int HALT_CNT_W = 16;
    localparam logic [PC_W-1:0] PC_INCR = 32'd4;

`ifdef SINGLE_STEP_EN
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_STEP   = 2'd2
    } seq_state_t;
`else
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1
    } seq_state_t;
`endif

    // Saturating increment for the HLT entry counter
    function automatic logic [HALT_CNT_W-1:0] sat_inc(input logic [HALT_CNT_W-1:0] v);
        logic [HALT_CNT_W-1:0] r;
        if (v == {HALT_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(HALT_CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_sequencer_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector for a raw
// asynchronous button level; pulse is high for exactly one cycle.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // Synchronizer chain plus delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign pulse = sync2_r & ~prev_r;

endmodule

// File: rtl/pc_sequencer.sv
// PC next-value selection and HLT/resume sequencer with registered status.
// Optional single-step support is enabled by defining SINGLE_STEP_EN.
module pc_sequencer
    import pc_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PC_W-1:0]       pc_cur,
    input  logic                  branch_taken,
    input  logic [PC_W-1:0]       branch_target,
    input  logic                  halt_instr,
    input  logic                  resume,
    input  logic                  step,
    output logic [PC_W-1:0]       pc_next,
    output logic                  halt,
    output logic                  cont,
    output logic                  misalign,
    output logic [HALT_CNT_W-1:0] halt_cnt
);

    seq_state_t            state_r;
    seq_state_t            state_nxt_s;
    logic                  resume_edge_s;
    logic                  step_edge_s;
    logic                  hlt_entry_s;
    logic                  misalign_set_s;
    logic                  take_branch_s;
    logic                  halt_r;
    logic                  cont_r;
    logic                  misalign_r;
    logic [HALT_CNT_W-1:0] halt_cnt_r;

    sync_edge u_resume_sync (.clk(clk), .rst(rst), .din(resume), .pulse(resume_edge_s));
    sync_edge u_step_sync   (.clk(clk), .rst(rst), .din(step),   .pulse(step_edge_s));

`ifndef SINGLE_STEP_EN
    logic unused_step_s;
    assign unused_step_s = step_edge_s;
`endif

    // Next-state decode; a resume edge outranks a step edge
    always_comb begin
        state_nxt_s = state_r;
        hlt_entry_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (halt_instr) begin
                    state_nxt_s = ST_HALTED;
                    hlt_entry_s = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (resume_edge_s) begin
                    state_nxt_s = ST_RUN;
`ifdef SINGLE_STEP_EN
                end else if (step_edge_s) begin
                    state_nxt_s = ST_STEP;
`endif
                end else begin
                    state_nxt_s = ST_HALTED;
                end
            end
`ifdef SINGLE_STEP_EN
            ST_STEP: state_nxt_s = ST_HALTED;
`endif
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // A halt takes precedence over a branch in the same cycle
    always_comb begin
        take_branch_s  = 1'b0;
        misalign_set_s = 1'b0;
        if (state_r != ST_HALTED) begin
            take_branch_s = branch_taken & ~halt_instr;
        end else begin
            take_branch_s = 1'b0;
        end
        if (state_r == ST_RUN) begin
            misalign_set_s = take_branch_s & (branch_target[1:0] != 2'b00);
        end else begin
            misalign_set_s = 1'b0;
        end
    end

    // Next PC: forced to zero under reset, word-aligned branch target or sequential
    always_comb begin
        pc_next = pc_cur + PC_INCR;
        if (rst) begin
            pc_next = {PC_W{1'b0}};
        end else if (take_branch_s) begin
            pc_next = {branch_target[PC_W-1:2], 2'b00};
        end else begin
            pc_next = pc_cur + PC_INCR;
        end
    end

    // State and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            halt_r     <= 1'b0;
            cont_r     <= 1'b0;
            misalign_r <= 1'b0;
            halt_cnt_r <= {HALT_CNT_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            halt_r     <= (state_nxt_s != ST_RUN);
`ifdef SINGLE_STEP_EN
            cont_r     <= (state_nxt_s == ST_STEP);
`else
            cont_r     <= 1'b0;
`endif
            misalign_r <= misalign_r | misalign_set_s;
            if (hlt_entry_s) begin
                halt_cnt_r <= sat_inc(halt_cnt_r);
            end else begin
                halt_cnt_r <= halt_cnt_r;
            end
        end
    end

    assign halt     = halt_r;
    assign cont     = cont_r;
    assign misalign = misalign_r;
    assign halt_cnt = halt_cnt_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer with hand-written halt,
// resume, saturation, reset and (optionally) single-step sequences.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_cur;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        halt_instr;
    logic        resume;
    logic        step;
    logic [31:0] pc_next;
    logic        halt;
    logic        cont;
    logic        misalign;
    logic [15:0] halt_cnt;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .branch_taken(branch_taken),
        .branch_target(branch_target), .halt_instr(halt_instr), .resume(resume),
        .step(step), .pc_next(pc_next), .halt(halt), .cont(cont),
        .misalign(misalign), .halt_cnt(halt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] exp_pc;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_halt(input logic val, input int max_cyc);
        int n;
        n = 0;
        while (halt !== val && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (halt !== val) begin
            errors++;
            $display("FAIL wait_halt: halt=%b expected %b after %0d cycles", halt, val, n);
        end
    endtask

    // Enter HALTED from RUN via HLT, check count, then resume back to RUN
    task automatic halt_and_resume(input logic [15:0] exp_cnt);
        halt_instr = 1'b1;
        @(negedge clk);
        halt_instr = 1'b0;
        chk("hr_halt", 32'(halt), 32'd1);
        chk("hr_cnt", 32'(halt_cnt), 32'(exp_cnt));
        resume = 1'b1;
        wait_halt(1'b0, 10);
        resume = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int cont_cycles;

        vecs[0] = '{32'h0000_0100, 1'b0, 32'h0000_0203, 32'h0000_0104, 1'b0};
        vecs[1] = '{32'h0000_1000, 1'b1, 32'h0000_2000, 32'h0000_2000, 1'b0};
        vecs[2] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[3] = '{32'h7FFF_FFFC, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0};
        vecs[4] = '{32'h0000_0100, 1'b1, 32'h0000_0206, 32'h0000_0204, 1'b1};
        vecs[5] = '{32'h0000_0008, 1'b1, 32'h0000_0013, 32'h0000_0010, 1'b1};
        vecs[6] = '{32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b1};

        rst = 1'b1; pc_cur = 32'h0000_0100; branch_taken = 1'b0;
        branch_target = 32'h0; halt_instr = 1'b0; resume = 1'b0; step = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pc_next", pc_next, 32'h0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_cont", 32'(cont), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_halt_cnt", 32'(halt_cnt), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            pc_cur = vecs[i].pc; branch_taken = vecs[i].br; branch_target = vecs[i].tgt;
            #1;
            chk($sformatf("vec%0d_pc_next", i), pc_next, vecs[i].exp_pc);
            @(negedge clk);
            chk($sformatf("vec%0d_misalign", i), 32'(misalign), 32'(vecs[i].exp_mis));
            chk($sformatf("vec%0d_halt", i), 32'(halt), 32'd0);
        end
        branch_taken = 1'b0; pc_cur = 32'h0000_0100;
        repeat (100) @(negedge clk);
        chk("misalign_sticky", 32'(misalign), 32'd1);

        // Halt combined with a misaligned branch
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        pc_cur = 32'h0000_0040; halt_instr = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0003;
        #1;
        chk("hlt_pc_next", pc_next, 32'h0000_0044);
        @(negedge clk);
        halt_instr = 1'b0; branch_taken = 1'b0;
        chk("hlt_halt", 32'(halt), 32'd1);
        chk("hlt_cnt", 32'(halt_cnt), 32'd1);
        chk("hlt_no_misalign", 32'(misalign), 32'd0);
        chk("halted_pc_next", pc_next, 32'h0000_0044);
        chk("halted_cont", 32'(cont), 32'd0);

        // Resume latency: edges k and k+1 keep halt, k+2 clears it
        resume = 1'b1;
        @(negedge clk); chk("resume_k", 32'(halt), 32'd1);
        @(negedge clk); chk("resume_k1", 32'(halt), 32'd1);
        @(negedge clk); chk("resume_k2", 32'(halt), 32'd0);
        halt_instr = 1'b1;
        @(negedge clk);
        halt_instr = 1'b0;
        chk("rehalt_cnt", 32'(halt_cnt), 32'd2);
        repeat (4) @(negedge clk);
        chk("held_resume_no_event", 32'(halt), 32'd1);
        resume = 1'b0;
        repeat (3) @(negedge clk);
        resume = 1'b1;
        wait_halt(1'b0, 10);
        resume = 1'b0;
        repeat (3) @(negedge clk);

        // Reset while halted with count 3 and misalign set
        branch_taken = 1'b1; branch_target = 32'h0000_0101;
        @(negedge clk);
        branch_taken = 1'b0;
        halt_instr = 1'b1;
        @(negedge clk);
        halt_instr = 1'b0;
        chk("pre_rst_cnt", 32'(halt_cnt), 32'd3);
        chk("pre_rst_misalign", 32'(misalign), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_pc_zero", pc_next, 32'h0);
        @(negedge clk);
        chk("mid_rst_halt", 32'(halt), 32'd0);
        chk("mid_rst_cnt", 32'(halt_cnt), 32'd0);
        chk("mid_rst_misalign", 32'(misalign), 32'd0);
        rst = 1'b0;
        pc_cur = 32'h0000_0200; branch_taken = 1'b1; branch_target = 32'h0000_0300;
        #1;
        chk("post_rst_run_branch", pc_next, 32'h0000_0300);
        branch_taken = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_no_cont", 32'(cont), 32'd0);

        // Counter saturation
        force dut.halt_cnt_r = 16'hFFFD;
        @(negedge clk);
        release dut.halt_cnt_r;
        @(negedge clk);
        chk("sat_preload", 32'(halt_cnt), 32'h0000_FFFD);
        halt_and_resume(16'hFFFE);
        halt_and_resume(16'hFFFF);
        halt_and_resume(16'hFFFF);

        // Step handling while halted
        halt_instr = 1'b1;
        @(negedge clk);
        halt_instr = 1'b0;
        step = 1'b1; cont_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 1) step = 1'b0;
            if (cont) cont_cycles++;
        end
`ifdef SINGLE_STEP_EN
        chk("step_cont_len", 32'(cont_cycles), 32'd1);
`else
        chk("step_cont_off", 32'(cont_cycles), 32'd0);
`endif
        chk("step_still_halt", 32'(halt), 32'd1);
        step = 1'b1; resume = 1'b1; cont_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 1) begin step = 1'b0; resume = 1'b0; end
            if (cont) cont_cycles++;
        end
        chk("step_resume_cont", 32'(cont_cycles), 32'd0);
        chk("step_resume_run", 32'(halt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
